// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM states, tag width and one-hot decode.
package ram_ctrl_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int MAX_REQ = 16;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] id);
        logic [MAX_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ram_tdp_port_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched upward from ptr, zero latency.
// Pointer moves past the winner only on a transfer; no backpressure of its own.
module rr_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = idw(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr_advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int             idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_advance) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_tdp_port_arb.sv
// Shares one RAM port among NUM_REQ requesters (round-robin, zero-latency grant), with optional clear sweep.
// Reads return RD_LATENCY cycles after grant to the tagged requester; responses cannot be backpressured.
module ram_tdp_port_arb
    import ram_ctrl_pkg::*;
#(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 36,
    parameter int                    ADDR_WIDTH = 14,
    parameter int                    RAM_DEPTH  = 4096,
    parameter int                    RD_LATENCY = 2,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          init_done
);

    localparam int IDW = idw(NUM_REQ);

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          sweep_q, sweep_d;
    logic                           init_done_q, init_done_d;
    logic [NUM_REQ-1:0]             arb_req, grant;
    logic [IDW-1:0]                 grant_idx;
    logic                           rd_push;
    logic [RD_LATENCY-1:0]          tag_vld_q;
    logic [RD_LATENCY-1:0][IDW-1:0] tag_id_q;
    logic [MAX_REQ-1:0]             rsp_oh;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (arb_req),
        .ptr_advance (|grant),
        .grant       (grant),
        .grant_idx   (grant_idx)
    );

    // Outputs are gated by rst_n so the port is quiet during the reset cycle itself.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        arb_req     = '0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        if (rst_n) begin
            case (state_q)
                INIT: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = sweep_q;
                    ram_din  = INIT_VALUE;
                    sweep_d  = sweep_q + ADDR_WIDTH'(1);
                    if (sweep_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        state_d     = RUN;
                        sweep_d     = '0;
                        init_done_d = 1'b1;
                    end
                end
                RUN: begin
                    init_done_d = 1'b1;
                    arb_req     = req_valid;
                    ram_en      = |req_valid;
                    if (|grant) begin
                        ram_we   = req_we[grant_idx];
                        ram_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_din  = req_din[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rd_push   = (|grant) && !req_we[grant_idx];
    assign init_done = init_done_q;
    assign rsp_data  = ram_dout;

    always_comb begin
        rsp_oh    = onehot(4'(tag_id_q[RD_LATENCY-1]));
        rsp_valid = (rst_n && tag_vld_q[RD_LATENCY-1]) ? rsp_oh[NUM_REQ-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (INIT_EN != 0) ? INIT : RUN;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            init_done_q  <= init_done_d;
            tag_vld_q[0] <= rd_push;
            tag_id_q[0]  <= grant_idx;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

endmodule
